// File: rtl/pcie_datalink_pkg.sv
// ----------------------------------------------------------------------------
// pcie_datalink_pkg
//
// Shared definitions for the PCIe data-link layer blocks:
//   - link status, flow-control kind/type and DLLP receiver state enums
//   - DLLP type byte encodings (byte 0 of a DLLP)
//   - dllp_crc16(): the 16-bit DLLP CRC, returned in on-wire format, used by
//     both the RX decoder and the TX DLLP generator.
// ----------------------------------------------------------------------------
package pcie_datalink_pkg;

    // Data-link state as reported by the DL control state machine.
    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_INIT     = 2'd1,
        DL_ACTIVE   = 2'd2
    } pcie_dl_status_e;

    // Flow-control DLLP kind.
    typedef enum logic [1:0] {
        FC_INIT1  = 2'd0,
        FC_INIT2  = 2'd1,
        FC_UPDATE = 2'd2
    } pcie_fc_kind_e;

    // Flow-control credit type; the values match bits [5:4] of the DLLP type byte.
    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } pcie_fc_type_e;

    // DLLP receiver framing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } dllp_rx_state_e;

    // DLLP type encodings (byte 0). FC types carry the VC number in bits [2:0].
    localparam logic [7:0] DllpAck             = 8'h00;
    localparam logic [7:0] DllpNak             = 8'h10;
    localparam logic [7:0] DllpPmEnterL1       = 8'h20;
    localparam logic [7:0] DllpPmEnterL23      = 8'h21;
    localparam logic [7:0] DllpPmActiveReqL1   = 8'h23;
    localparam logic [7:0] DllpPmRequestAck    = 8'h24;
    localparam logic [7:0] DllpVendor          = 8'h30;
    localparam logic [7:0] DllpInitFc1P        = 8'h40;
    localparam logic [7:0] DllpInitFc1Np       = 8'h50;
    localparam logic [7:0] DllpInitFc1Cpl      = 8'h60;
    localparam logic [7:0] DllpInitFc2P        = 8'hC0;
    localparam logic [7:0] DllpInitFc2Np       = 8'hD0;
    localparam logic [7:0] DllpInitFc2Cpl      = 8'hE0;
    localparam logic [7:0] DllpUpdateFcP       = 8'h80;
    localparam logic [7:0] DllpUpdateFcNp      = 8'h90;
    localparam logic [7:0] DllpUpdateFcCpl     = 8'hA0;

    localparam logic [15:0] DllpCrcPoly = 16'h100B;
    localparam logic [15:0] DllpCrcSeed = 16'hFFFF;

    // CRC-16 over DLLP bytes 0..3 (byte 0 in bits [7:0]). Bits enter the
    // LFSR in transmission order: byte 0 first, bit 0 of each byte first.
    // The remainder is complemented and bit-reversed within each byte, so the
    // return value is exactly the wire format: [7:0] is DLLP byte 4 and
    // [15:8] is DLLP byte 5 (CRC bit 15 lands in byte 4 bit 0).
    function automatic logic [15:0] dllp_crc16(input logic [31:0] body);
        logic [15:0] crc;
        logic [15:0] wire_crc;
        logic        fb;
        crc = DllpCrcSeed;
        for (int i = 0; i < 32; i++) begin
            fb  = crc[15] ^ body[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? DllpCrcPoly : 16'h0000);
        end
        crc = ~crc;
        for (int i = 0; i < 8; i++) begin
            wire_crc[i]     = crc[15-i];
            wire_crc[8 + i] = crc[7-i];
        end
        return wire_crc;
    endfunction

endpackage

// File: rtl/dllp_rx_decode.sv
// ----------------------------------------------------------------------------
// dllp_rx_decode
//
// Receive-side DLLP decoder. Takes 6-byte DLLPs from the TLP/DLLP demux as a
// two-beat 32-bit AXI-Stream (beat 0: bytes 0..3, beat 1: CRC bytes 4..5),
// checks the CRC and turns good DLLPs into registered one-cycle event pulses.
// The stream is never back-pressured.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   link_status_i          data-link state, sampled with the CRC beat
//   s_axis_*               DLLP stream in (tready is 1 from the first edge
//                          after reset release; tuser is ignored)
//   ack_valid_o/nak/seq    Ack/Nak event for the replay buffer
//   fc_valid_o/kind/type/
//   fc_hdr_o/fc_data_o     InitFC1/InitFC2/UpdateFC event for credit tracking
//   other_valid_o/type     any other DLLP (PM, vendor) with a good CRC
//   crc_err_cnt_o          saturating count of CRC failures
//   malformed_cnt_o        saturating count of framing errors
// ----------------------------------------------------------------------------
module dllp_rx_decode
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pcie_dl_status_e       link_status_i,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,

    output logic                  ack_valid_o,
    output logic                  ack_nak_o,
    output logic [11:0]           ack_seq_o,

    output logic                  fc_valid_o,
    output pcie_fc_kind_e         fc_kind_o,
    output pcie_fc_type_e         fc_type_o,
    output logic [7:0]            fc_hdr_o,
    output logic [11:0]           fc_data_o,

    output logic                  other_valid_o,
    output logic [7:0]            other_type_o,

    output logic [15:0]           crc_err_cnt_o,
    output logic [15:0]           malformed_cnt_o
);

    // The framing and byte lane mapping below assume a 32-bit stream.
    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("dllp_rx_decode supports DATA_WIDTH == 32 only");
        end
    endgenerate

    dllp_rx_state_e state_q, state_d;
    logic [31:0]    cap_q, cap_d;
    logic           tready_q;

    logic           ack_valid_q, ack_nak_q;
    logic [11:0]    ack_seq_q;
    logic           fc_valid_q;
    pcie_fc_kind_e  fc_kind_q;
    pcie_fc_type_e  fc_type_q;
    logic [7:0]     fc_hdr_q;
    logic [11:0]    fc_data_q;
    logic           other_valid_q;
    logic [7:0]     other_type_q;
    logic [15:0]    crc_err_cnt_q, malformed_cnt_q;

    logic           beat_hs;
    logic           frame_done;
    logic           malformed;
    logic           crc_ok;
    logic           is_ack;
    logic           is_fc;
    pcie_fc_kind_e  dec_kind;
    pcie_fc_type_e  dec_type;
    logic           ack_fire, fc_fire, other_fire, crc_fail;
    logic [7:0]     b0, b1, b2, b3;
    logic           unused_tuser;

    assign unused_tuser = ^s_axis_tuser;

    assign beat_hs = s_axis_tvalid & tready_q;

    assign b0 = cap_q[7:0];
    assign b1 = cap_q[15:8];
    assign b2 = cap_q[23:16];
    assign b3 = cap_q[31:24];

    // Framing FSM: accepts beat 0 into the capture register, flags the CRC
    // beat, and counts anything that does not fit the two-beat shape. A
    // non-final beat with a partial tkeep in idle is also treated as
    // malformed and the rest of that packet is flushed.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        frame_done = 1'b0;
        malformed  = 1'b0;
        if (beat_hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tlast) begin
                        malformed = 1'b1;
                    end else if (s_axis_tkeep == {KEEP_WIDTH{1'b1}}) begin
                        cap_d   = s_axis_tdata;
                        state_d = ST_BODY;
                    end else begin
                        malformed = 1'b1;
                        state_d   = ST_FLUSH;
                    end
                end
                ST_BODY: begin
                    if (!s_axis_tlast) begin
                        malformed = 1'b1;
                        state_d   = ST_FLUSH;
                    end else if (s_axis_tkeep[1:0] == 2'b11) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        malformed = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Type decode of the captured byte 0. FC kind/type come from the upper
    // nibble; bit 3 of byte 0 is not part of the FC encoding.
    always_comb begin
        is_fc    = 1'b0;
        dec_kind = FC_INIT1;
        dec_type = FC_P;
        case (b0[7:4])
            4'h4: begin is_fc = 1'b1; dec_kind = FC_INIT1;  dec_type = FC_P;   end
            4'h5: begin is_fc = 1'b1; dec_kind = FC_INIT1;  dec_type = FC_NP;  end
            4'h6: begin is_fc = 1'b1; dec_kind = FC_INIT1;  dec_type = FC_CPL; end
            4'hC: begin is_fc = 1'b1; dec_kind = FC_INIT2;  dec_type = FC_P;   end
            4'hD: begin is_fc = 1'b1; dec_kind = FC_INIT2;  dec_type = FC_NP;  end
            4'hE: begin is_fc = 1'b1; dec_kind = FC_INIT2;  dec_type = FC_CPL; end
            4'h8: begin is_fc = 1'b1; dec_kind = FC_UPDATE; dec_type = FC_P;   end
            4'h9: begin is_fc = 1'b1; dec_kind = FC_UPDATE; dec_type = FC_NP;  end
            4'hA: begin is_fc = 1'b1; dec_kind = FC_UPDATE; dec_type = FC_CPL; end
            default: ;
        endcase
    end

    // CRC check and event qualification. The CRC beat's low 16 bits are
    // bytes 4 and 5, which is the format dllp_crc16 returns.
    assign crc_ok = (dllp_crc16(cap_q) == s_axis_tdata[15:0]);
    assign is_ack = (b0 == DllpAck) || (b0 == DllpNak);

    assign crc_fail   = frame_done & ~crc_ok;
    assign ack_fire   = frame_done & crc_ok & is_ack & (link_status_i == DL_ACTIVE);
    assign fc_fire    = frame_done & crc_ok & is_fc & (b0[2:0] == 3'd0)
                      & (link_status_i != DL_INACTIVE);
    assign other_fire = frame_done & crc_ok & ~is_ack & ~is_fc;

    // Framing state, capture register and the always-ready flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cap_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            tready_q <= 1'b1;
        end
    end

    // Event outputs: valids pulse for one cycle, payloads hold until the
    // next event of the same class.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_valid_q   <= 1'b0;
            ack_nak_q     <= 1'b0;
            ack_seq_q     <= '0;
            fc_valid_q    <= 1'b0;
            fc_kind_q     <= FC_INIT1;
            fc_type_q     <= FC_P;
            fc_hdr_q      <= '0;
            fc_data_q     <= '0;
            other_valid_q <= 1'b0;
            other_type_q  <= '0;
        end else begin
            ack_valid_q   <= ack_fire;
            fc_valid_q    <= fc_fire;
            other_valid_q <= other_fire;
            if (ack_fire) begin
                ack_nak_q <= (b0 == DllpNak);
                ack_seq_q <= {b2[3:0], b3};
            end
            if (fc_fire) begin
                fc_kind_q <= dec_kind;
                fc_type_q <= dec_type;
                fc_hdr_q  <= {b1[5:0], b2[7:6]};
                fc_data_q <= {b2[3:0], b3};
            end
            if (other_fire) begin
                other_type_q <= b0;
            end
        end
    end

    // Saturating error counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_err_cnt_q   <= '0;
            malformed_cnt_q <= '0;
        end else begin
            if (crc_fail && (crc_err_cnt_q != 16'hFFFF)) begin
                crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
            end
            if (malformed && (malformed_cnt_q != 16'hFFFF)) begin
                malformed_cnt_q <= malformed_cnt_q + 16'd1;
            end
        end
    end

    assign s_axis_tready   = tready_q;
    assign ack_valid_o     = ack_valid_q;
    assign ack_nak_o       = ack_nak_q;
    assign ack_seq_o       = ack_seq_q;
    assign fc_valid_o      = fc_valid_q;
    assign fc_kind_o       = fc_kind_q;
    assign fc_type_o       = fc_type_q;
    assign fc_hdr_o        = fc_hdr_q;
    assign fc_data_o       = fc_data_q;
    assign other_valid_o   = other_valid_q;
    assign other_type_o    = other_type_q;
    assign crc_err_cnt_o   = crc_err_cnt_q;
    assign malformed_cnt_o = malformed_cnt_q;

endmodule

// File: doc/dllp_rx_decode.md
# dllp_rx_decode

Receive-side DLLP decoder on the DLLP branch of the link-layer RX path, directly downstream of the TLP/DLLP demultiplexer. Consumes 6-byte DLLPs on a 32-bit AXI-Stream and checks each one against its CRC-16. Decodes good DLLPs into single-cycle event pulses:

- Ack/Nak events, consumed by the replay buffer.
- InitFC1, InitFC2 and UpdateFC events, consumed by the flow-control credit tracker.

Never back-pressures its source.

## Interface
Parameters:
- DATA_WIDTH, 32, stream width; only 32 is supported, and elaboration fails otherwise.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 2, tuser width; tuser is ignored.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- link_status_i  in  pcie_dl_status_e  link state (DL_INACTIVE, DL_INIT, DL_ACTIVE).
- s_axis_tdata / tkeep / tvalid / tlast / tuser  in  32 / 4 / 1 / 1 / USER_WIDTH  DLLP stream; byte n is on tdata[8n+7:8n].
- s_axis_tready  out  1  always 1 out of reset.
- ack_valid_o  out  1  one-cycle pulse: Ack/Nak decoded.
- ack_nak_o  out  1  0=Ack, 1=Nak.
- ack_seq_o  out  12  AckNak_Seq_Num.
- fc_valid_o  out  1  one-cycle pulse: FC DLLP decoded.
- fc_kind_o  out  pcie_fc_kind_e  FC_INIT1, FC_INIT2, FC_UPDATE.
- fc_type_o  out  pcie_fc_type_e  FC_P, FC_NP, FC_CPL.
- fc_hdr_o  out  8  HdrFC.
- fc_data_o  out  12  DataFC.
- other_valid_o  out  1  pulse: PM/vendor DLLP with good CRC.
- other_type_o  out  8  DLLP byte 0 of that DLLP.
- crc_err_cnt_o  out  16  saturating count of CRC failures.
- malformed_cnt_o  out  16  saturating count of framing errors.

## Operation
Framing:
- Beat 0 carries bytes 0–3, with tkeep=4'hF and tlast=0.
- Beat 1 carries CRC bytes 4–5, with tkeep=4'h3 and tlast=1.

FSM states: ST_IDLE, ST_BODY, ST_FLUSH.
- ST_IDLE:
  - Beat with tlast=0 and tkeep=4'hF: capture bytes 0–3 and go to ST_BODY.
  - Beat with tlast=1: malformed. Increment malformed_cnt_o and stay in ST_IDLE.
- ST_BODY:
  - Beat with tlast=1 and tkeep[1:0]=2'b11: check CRC, decode, go to ST_IDLE.
  - Beat with tlast=0: malformed. Increment malformed_cnt_o and go to ST_FLUSH.
- ST_FLUSH: discard beats until a beat with tlast=1, then go to ST_IDLE.

CRC check:
- PCIe DLLP CRC-16: poly 16'h100B, seed 16'hFFFF, computed over bytes 0–3.
- The result is complemented and bit-mapped onto bytes 4–5 per PCIe Base Spec §3.6.2.1.
- On mismatch: no event is produced and crc_err_cnt_o increments.

Decode of byte 0 (b0) when the CRC is good:
- 8'h00 → Ack; 8'h10 → Nak.
  - ack_seq_o = {b2[3:0], b3}.
  - Emitted only when link_status_i==DL_ACTIVE; otherwise the DLLP is dropped silently.
- b0[7:4] selects the FC DLLP:
  - 4/5/6 → FC_INIT1 P/NP/CPL.
  - C/D/E → FC_INIT2 P/NP/CPL.
  - 8/9/A → FC_UPDATE P/NP/CPL.
- FC DLLPs:
  - Only VC0 (b0[2:0]==0) is accepted; other VCs are dropped silently.
  - fc_hdr_o = {b1[5:0], b2[7:6]}; fc_data_o = {b2[3:0], b3}.
  - Emitted when link_status_i!=DL_INACTIVE.
- Any other b0 → other_valid_o.

Counters increment by 1 and saturate at 16'hFFFF.

## Timing
- Reset values:
  - s_axis_tready=0 and all valid pulses=0.
  - Data outputs and counters=0; FSM in ST_IDLE.
- s_axis_tready goes to 1 on the first clock edge after rst_ni deasserts and stays high.
- Latency: event outputs are registered and pulse exactly one cycle, in the cycle after the beat-1 handshake.
- Data outputs hold their value until the next event of the same class.
- Back-to-back DLLPs at full rate (one beat per cycle) produce one pulse every 2 cycles with no loss.
- link_status_i is sampled in the beat-1 handshake cycle.
- Reset asserted mid-DLLP: the captured partial DLLP is discarded and no pulse is produced.
- A CRC error and a malformed event cannot coincide in the same cycle.

## Structure
- pcie_datalink_pkg gains:
  - pcie_fc_kind_e and pcie_fc_type_e.
  - DLLP type localparams: DllpAck=8'h00, DllpNak=8'h10, etc.
  - A function dllp_crc16(input logic [31:0]) returning logic [15:0], shared with the TX DLLP generator.
- No sub-module: one FSM, capture register, CRC function, output registers.

## Test plan
- Ack with seq 12'h005, good CRC, DL_ACTIVE → ack_valid_o pulses one cycle after tlast, with ack_nak_o=0 and ack_seq_o=12'h005.
- UpdateFC-NP with hdr 8'h2A, data 12'h3C1, in DL_INIT → fc_valid_o pulses with FC_UPDATE, FC_NP, 8'h2A, 12'h3C1.
- Nak seq 12'hFFF with the CRC bit 0 flipped → no pulse; crc_err_cnt_o reads 1.
- 1-beat packet with tlast on beat 0, then a 3-beat packet, then a good InitFC1-P → malformed_cnt_o reads 2, and the InitFC1-P event is still reported.
- 100 back-to-back Acks with seq 0..99 and tvalid held high → 100 pulses in order, tready never low.
- rst_ni pulsed low between beat 0 and beat 1 of an Ack → no pulse, and all outputs are 0 after reset.
